cn_msg_gen: RTL and testbench
=============================

Name: cn_msg_gen

Overview:
- Check-node message generator for the min-sum LDPC decoder: the read-out side of the min/second-min tracker.
- Accepts one check node's reduced state: min1, min2, index of min1, and the per-edge input sign vector.
- Serially emits one signed check-to-variable message per edge, index 0..SIZE-1, over a valid/ready stream.
- Sits between the check-node reduction stage and the variable-node update / message memory write port.

Parameters:
- DATA_WIDTH, 6, width of magnitudes, indices and signed messages
- SIZE, 8, check-node degree (edges emitted per load); 2 <= SIZE <= 2^DATA_WIDTH - 1
- OFFSET, 0, offset min-sum correction subtracted from magnitudes, saturating at 0

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  load request carrying check-node state
- in_ready  out  1  high only in IDLE
- min_value1  in  DATA_WIDTH  smallest |input| (unsigned, <= 2^(DATA_WIDTH-1)-1)
- min_value2  in  DATA_WIDTH  second smallest |input|
- min_index1  in  DATA_WIDTH  edge index of min_value1
- sign_vec  in  SIZE  bit i = sign of input message on edge i (1 = negative)
- out_valid  out  1  message valid
- out_ready  in  1  downstream accepts message
- out_index  out  DATA_WIDTH  edge index of current message
- out_value  out  DATA_WIDTH  signed check-to-variable message
- busy  out  1  high in EMIT
- done  out  1  one-cycle pulse after last edge accepted

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, out_index=0, out_value=0, busy=0, done=0, internal registers cleared.
- States: IDLE, EMIT.
- IDLE: on in_valid&&in_ready, register min_value1, min_value2, min_index1, sign_vec, and parity = XOR-reduce(sign_vec). Go to EMIT with edge counter=0.
- Latency: out_valid rises the cycle after the load handshake.
- Magnitude rules:
  - m1 = (min_value1 > OFFSET) ? min_value1 - OFFSET : 0; m2 likewise from min_value2. Computed once at load.
  - Edge i magnitude = m2 if i == min_index1, else m1.
- Sign rules:
  - Edge i sign = parity XOR sign_vec[i].
  - out_value = sign ? -mag : mag (two's complement). mag=0 always gives out_value=0.
- EMIT handshake:
  - out_value/out_index are registered and stay stable while out_valid && !out_ready.
  - On out_valid && out_ready with index < SIZE-1: load the next edge in the same cycle, no bubble.
  - On out_valid && out_ready with index == SIZE-1: go to IDLE next cycle, out_valid=0, done=1 for exactly one cycle, in_ready=1.
- in_valid during EMIT is ignored (in_ready=0); upstream holds it.
- min_index1 >= SIZE (tracker never updated): every edge uses m1.
- min_value1 == min_value2 ties: the edge at min_index1 gets m2, which is numerically identical.
- rst_n asserted mid-EMIT: immediately abort to reset values. No done pulse and no further messages for that check node.
- busy = (state == EMIT). done never coincides with out_valid.

Decomposition:
- Shared decoder package: state encoding (IDLE/EMIT), message width constant DATA_WIDTH, and a saturating-offset function shared with future normalized min-sum variants.
- One natural sub-module: cn_msg_sign_mag, a purely combinational sign/magnitude-to-two's-complement formatter (inputs mag, sign; output signed value). It is reused by the variable-node side.

Test Plan:
- SIZE=8, OFFSET=0; load min1=3, min2=5, idx1=2, sign_vec=8'b00000101, out_ready=1 -> parity=0. Beats idx0..7 = -3,+3,-5,+3,+3,+3,+3,+3, one per cycle. First beat one cycle after load. done pulses after idx7.
- Same data, sign_vec=8'b00000001 (parity=1) -> idx0 +3, idx1 -3, idx2 -5, idx3..7 -3.
- OFFSET=1, min1=1, min2=4, idx1=7, sign_vec=0 -> idx0..6 = 0, idx7 = +3.
- Backpressure: drop out_ready for 3 cycles at idx3 -> idx3 value and index held stable. Total 8 accepted beats, no duplicates or skips. in_valid held high throughout is not accepted until done.
- min_index1=63 (>= SIZE), min1=31, min2=31, sign_vec=8'hFF (parity=0) -> all 8 beats = -31.
- Assert rst_n low at idx4 -> out_valid, busy, done drop asynchronously. After release in_ready=1, and a new load restarts at idx0.

Source files
------------

// File: rtl/cn_msg_gen_pkg.sv
// Shared decoder definitions for check-node message generation.
// Holds the FSM encoding, the message width and the offset-correction helper.
package cn_msg_gen_pkg;

    localparam int unsigned CN_DATA_WIDTH = 6;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } cn_state_t;

    // Offset min-sum correction: subtract and clamp at zero.
    function automatic int unsigned sat_offset(input int unsigned mag, input int unsigned offset);
        return (mag > offset) ? mag - offset : 32'd0;
    endfunction

endpackage

// File: rtl/cn_msg_sign_mag.sv
// Sign/magnitude to two's-complement formatter for decoder messages.
module cn_msg_sign_mag
    import cn_msg_gen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CN_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] mag,
    input  logic                  sign,
    output logic [DATA_WIDTH-1:0] value
);

    always_comb begin
        value = sign ? ('0 - mag) : mag;
    end

endmodule

// File: rtl/cn_msg_gen.sv
// Check-node message generator: expands min1/min2/index/sign state into one
// signed check-to-variable message per edge over a valid/ready stream.
module cn_msg_gen
    import cn_msg_gen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CN_DATA_WIDTH,
    parameter int unsigned SIZE       = 8,
    parameter int unsigned OFFSET     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] min_value1,
    input  logic [DATA_WIDTH-1:0] min_value2,
    input  logic [DATA_WIDTH-1:0] min_index1,
    input  logic [SIZE-1:0]       sign_vec,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_index,
    output logic [DATA_WIDTH-1:0] out_value,
    output logic                  busy,
    output logic                  done
);

    localparam logic [DATA_WIDTH-1:0] LAST_IDX = DATA_WIDTH'(SIZE - 1);

    cn_state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] m1_q, m2_q, idx1_q;
    logic [SIZE-1:0]       sign_q;
    logic                  parity_q;

    logic                  load, accept, last;
    logic [DATA_WIDTH-1:0] ld_m1, ld_m2;
    logic [DATA_WIDTH-1:0] src_m1, src_m2, src_idx1;
    logic [SIZE-1:0]       src_sign;
    logic                  src_parity;
    logic [DATA_WIDTH-1:0] edge_idx, edge_mag, edge_value;
    logic                  edge_bit, edge_sign;

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q == EMIT);

    assign ld_m1 = DATA_WIDTH'(sat_offset(32'(min_value1), OFFSET));
    assign ld_m2 = DATA_WIDTH'(sat_offset(32'(min_value2), OFFSET));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_valid && out_ready) begin
                    accept = 1'b1;
                    if (out_index == LAST_IDX) begin
                        last    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The first beat is formatted straight from the load inputs so it is
    // registered on the handshake edge; later beats use the captured state.
    always_comb begin
        src_m1     = m1_q;
        src_m2     = m2_q;
        src_idx1   = idx1_q;
        src_sign   = sign_q;
        src_parity = parity_q;
        edge_idx   = out_index + DATA_WIDTH'(1);
        if (load) begin
            src_m1     = ld_m1;
            src_m2     = ld_m2;
            src_idx1   = min_index1;
            src_sign   = sign_vec;
            src_parity = ^sign_vec;
            edge_idx   = '0;
        end
        edge_mag = (edge_idx == src_idx1) ? src_m2 : src_m1;
        edge_bit = 1'b0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (edge_idx == DATA_WIDTH'(i)) begin
                edge_bit = src_sign[i];
            end
        end
        edge_sign = src_parity ^ edge_bit;
    end

    cn_msg_sign_mag #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fmt (
        .mag   (edge_mag),
        .sign  (edge_sign),
        .value (edge_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_q      <= '0;
            m2_q      <= '0;
            idx1_q    <= '0;
            sign_q    <= '0;
            parity_q  <= 1'b0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_value <= '0;
            done      <= 1'b0;
        end else begin
            done <= last;
            if (load) begin
                m1_q      <= ld_m1;
                m2_q      <= ld_m2;
                idx1_q    <= min_index1;
                sign_q    <= sign_vec;
                parity_q  <= ^sign_vec;
                out_valid <= 1'b1;
                out_index <= '0;
                out_value <= edge_value;
            end else if (last) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_index <= edge_idx;
                out_value <= edge_value;
            end
        end
    end

endmodule

// File: tb/tb_cn_msg_gen.sv
// Scoreboard bench for cn_msg_gen: OFFSET=0 and OFFSET=1 instances share clock and reset.
module tb_cn_msg_gen;

    typedef struct {
        logic [5:0] idx;
        logic [5:0] val;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy, done;
    logic [5:0] min1 = '0, min2 = '0, idx1 = '0, out_index, out_value;
    logic [7:0] sv = '0;

    logic       b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_busy, b_done;
    logic [5:0] b_min1 = '0, b_min2 = '0, b_idx1 = '0, b_out_index, b_out_value;
    logic [7:0] b_sv = '0;

    int tests = 0;
    int fails = 0;
    int beats0 = 0;
    beat_t q0[$];
    beat_t q1[$];

    always #5 clk = ~clk;

    cn_msg_gen #(.DATA_WIDTH(6), .SIZE(8), .OFFSET(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .min_value1(min1), .min_value2(min2), .min_index1(idx1), .sign_vec(sv),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .out_value(out_value), .busy(busy), .done(done)
    );

    cn_msg_gen #(.DATA_WIDTH(6), .SIZE(8), .OFFSET(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .min_value1(b_min1), .min_value2(b_min2), .min_index1(b_idx1), .sign_vec(b_sv),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_index(b_out_index),
        .out_value(b_out_value), .busy(b_busy), .done(b_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] model(input int m1, input int m2, input int id,
                                         input logic [7:0] s, input int off, input int i);
        int mag;
        logic neg;
        logic [5:0] m6;
        mag = (i == id) ? m2 : m1;
        mag = (mag > off) ? mag - off : 0;
        m6  = 6'(mag);
        neg = (^s) ^ s[i];
        return neg ? -m6 : m6;
    endfunction

    task automatic push0(input int m1, input int m2, input int id, input logic [7:0] s);
        for (int i = 0; i < 8; i++) q0.push_back('{6'(i), model(m1, m2, id, s, 0, i)});
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (rst_n && done) check("done_excl", {31'd0, out_valid}, 0);
        if (rst_n && out_valid && out_ready) begin
            if (q0.size() == 0) check("unexpected_beat", 1, 0);
            else begin
                e = q0.pop_front();
                check("idx", {26'd0, out_index}, {26'd0, e.idx});
                check("val", {26'd0, out_value}, {26'd0, e.val});
                beats0++;
            end
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (rst_n && b_out_valid && b_out_ready) begin
            if (q1.size() == 0) check("b_unexpected_beat", 1, 0);
            else begin
                e = q1.pop_front();
                check("b_idx", {26'd0, b_out_index}, {26'd0, e.idx});
                check("b_val", {26'd0, b_out_value}, {26'd0, e.val});
            end
        end
    end

    // Caller is positioned just after a rising edge.
    task automatic load0(input int m1, input int m2, input int id, input logic [7:0] s);
        int t = 0;
        while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
        check("in_ready_wait", {31'd0, in_ready}, 1);
        min1 = 6'(m1); min2 = 6'(m2); idx1 = 6'(id); sv = s;
        in_valid = 1'b1;
        push0(m1, m2, id, s);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("latency", {31'd0, out_valid}, 1);
        check("busy", {31'd0, busy}, 1);
    endtask

    task automatic wait_done0();
        int t = 0;
        while (!done && t < 100) begin @(posedge clk); #1; t++; end
        check("done_seen", {31'd0, done}, 1);
        check("done_idle", {31'd0, in_ready}, 1);
        @(posedge clk); #1;
        check("done_pulse", {31'd0, done}, 0);
        check("q0_drained", q0.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int start;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_index", {26'd0, out_index}, 0);
        check("rst_out_value", {26'd0, out_value}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_in_ready", {31'd0, in_ready}, 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        out_ready = 1'b1;
        load0(3, 5, 2, 8'b0000_0101);
        wait_done0();
        load0(3, 5, 2, 8'b0000_0001);
        wait_done0();
        load0(31, 31, 63, 8'hFF);
        wait_done0();

        b_out_ready = 1'b1;
        b_min1 = 6'd1; b_min2 = 6'd4; b_idx1 = 6'd7; b_sv = 8'h00;
        b_in_valid = 1'b1;
        for (int i = 0; i < 8; i++) q1.push_back('{6'(i), model(1, 4, 7, 8'h00, 1, i)});
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        check("b_latency", {31'd0, b_out_valid}, 1);
        t = 0;
        while (q1.size() != 0 && t < 50) begin @(posedge clk); #1; t++; end
        check("b_drained", q1.size(), 0);

        // Backpressure at idx3 with the next load request held pending.
        start = beats0;
        load0(3, 5, 2, 8'b0000_0101);
        min1 = 6'd7; min2 = 6'd9; idx1 = 6'd0; sv = 8'hA5;
        in_valid = 1'b1;
        t = 0;
        while (out_index != 6'd3 && t < 50) begin @(posedge clk); #1; t++; end
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("hold_idx", {26'd0, out_index}, 3);
            check("hold_val", {26'd0, out_value}, {26'd0, model(3, 5, 2, 8'b0000_0101, 0, 3)});
            check("hold_in_ready", {31'd0, in_ready}, 0);
        end
        out_ready = 1'b1;
        t = 0;
        while (!done && t < 50) begin
            check("emit_in_ready", {31'd0, in_ready}, 0);
            @(posedge clk); #1; t++;
        end
        check("bp_done", {31'd0, done}, 1);
        check("bp_beats", beats0 - start, 8);
        push0(7, 9, 0, 8'hA5);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("held_load", {31'd0, out_valid}, 1);
        wait_done0();

        // Asynchronous reset in the middle of a burst.
        load0(3, 5, 2, 8'b0000_0101);
        t = 0;
        while (out_index != 6'd4 && t < 50) begin @(posedge clk); #1; t++; end
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 0);
        check("arst_busy", {31'd0, busy}, 0);
        check("arst_done", {31'd0, done}, 0);
        check("arst_out_index", {26'd0, out_index}, 0);
        q0.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_in_ready", {31'd0, in_ready}, 1);
        load0(3, 5, 2, 8'b0000_0001);
        check("restart_idx", {26'd0, out_index}, 0);
        wait_done0();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
